// File: rtl/ex_skid_pipe_reg_if.sv
// EX/MEM boundary bundle: upstream valid/ready entry, downstream entry and cache ready.
// slave is the pipeline register's view, master the surrounding EX/MEM logic.
interface ex_skid_pipe_reg_if #(
  parameter int DATA_W = 10,
  parameter int SEL_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] rs_in;
  logic [DATA_W-1:0] rt_in;
  logic [DATA_W-1:0] ALU_result_in;
  logic [SEL_W-1:0]  reg_writesel_in;
  logic              reg_write_en_in;
  logic              RAM_writeEnable_in;
  logic              MemtoReg_in;
  logic              PC_en_in;

  logic              cache_Ready;
  logic              out_valid;
  logic [DATA_W-1:0] rs_out;
  logic [DATA_W-1:0] rt_out;
  logic [DATA_W-1:0] ALU_result_out;
  logic [SEL_W-1:0]  reg_writesel_out;
  logic              reg_write_en_out;
  logic              RAM_writeEnable_out;
  logic              MemtoReg_out;
  logic              PC_en_out;

  modport slave (
    input  in_valid, rs_in, rt_in, ALU_result_in, reg_writesel_in,
           reg_write_en_in, RAM_writeEnable_in, MemtoReg_in, PC_en_in, cache_Ready,
    output in_ready, out_valid, rs_out, rt_out, ALU_result_out, reg_writesel_out,
           reg_write_en_out, RAM_writeEnable_out, MemtoReg_out, PC_en_out
  );

  modport master (
    output in_valid, rs_in, rt_in, ALU_result_in, reg_writesel_in,
           reg_write_en_in, RAM_writeEnable_in, MemtoReg_in, PC_en_in, cache_Ready,
    input  in_ready, out_valid, rs_out, rt_out, ALU_result_out, reg_writesel_out,
           reg_write_en_out, RAM_writeEnable_out, MemtoReg_out, PC_en_out
  );
endinterface

// File: rtl/ex_skid_pipe_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer, flush and bubble gating; state on falling edge.
// Optional STALL_CNT_EN adds a saturating stall_count output.
module ex_skid_pipe_reg #(
  parameter int DATA_W = 10,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  ex_skid_pipe_reg_if.slave  bus
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  if (DATA_W < 1 || SEL_W < 1 || CNT_W < 1) begin : g_param_check
    $error("ex_skid_pipe_reg: widths must be positive");
  end

  typedef struct packed {
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] alu;
    logic [SEL_W-1:0]  sel;
    logic              reg_we;
    logic              ram_we;
    logic              mem2reg;
    logic              pc_en;
  } entry_t;

  entry_t in_ent;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   m_vld_q, m_vld_d;
  logic   s_vld_q, s_vld_d;
  logic   in_rdy_q, in_rdy_d;
  logic   acc, drn, m_upd;

  assign in_ent = '{rs:      bus.rs_in,
                    rt:      bus.rt_in,
                    alu:     bus.ALU_result_in,
                    sel:     bus.reg_writesel_in,
                    reg_we:  bus.reg_write_en_in,
                    ram_we:  bus.RAM_writeEnable_in,
                    mem2reg: bus.MemtoReg_in,
                    pc_en:   bus.PC_en_in};

  assign acc   = bus.in_valid & in_rdy_q;
  assign drn   = m_vld_q & bus.cache_Ready;
  assign m_upd = ~m_vld_q | drn;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_d     = '0;
      s_d     = '0;
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (m_upd) begin
      if (s_vld_q) begin
        // skid entry moves up; a same-cycle accept refills the skid slot
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = acc;
        if (acc) s_d = in_ent;
      end else if (acc) begin
        m_d     = in_ent;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (acc && !s_vld_q) begin
      s_d     = in_ent;
      s_vld_d = 1'b1;
    end
    in_rdy_d = ~s_vld_d;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      m_q      <= '0;
      s_q      <= '0;
      m_vld_q  <= 1'b0;
      s_vld_q  <= 1'b0;
      in_rdy_q <= 1'b1;
    end else begin
      m_q      <= m_d;
      s_q      <= s_d;
      m_vld_q  <= m_vld_d;
      s_vld_q  <= s_vld_d;
      in_rdy_q <= in_rdy_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // flush deliberately leaves the counter alone
  always_comb begin
    stall_d = stall_q;
    if (m_vld_q && !bus.cache_Ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(negedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

  assign bus.in_ready            = in_rdy_q;
  assign bus.out_valid           = m_vld_q;
  assign bus.rs_out              = m_q.rs;
  assign bus.rt_out              = m_q.rt;
  assign bus.ALU_result_out      = m_q.alu;
  assign bus.reg_writesel_out    = m_q.sel;
  assign bus.reg_write_en_out    = m_vld_q & m_q.reg_we;
  assign bus.RAM_writeEnable_out = m_vld_q & m_q.ram_we;
  assign bus.MemtoReg_out        = m_vld_q & m_q.mem2reg;
  assign bus.PC_en_out           = ~m_vld_q | m_q.pc_en;

endmodule

// File: tb/tb_ex_skid_pipe_reg.sv
// Self-checking bench for ex_skid_pipe_reg: directed plan steps then random traffic
// against a 2-deep queue model. Covers stall_count when STALL_CNT_EN is defined.
module tb_ex_skid_pipe_reg;
  localparam int DATA_W  = 10;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [DATA_W-1:0] alu;
    logic [SEL_W-1:0]  sel;
    logic              we;
    logic              ram;
    logic              m2r;
    logic              pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset, flush;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_count;
`endif

  ex_skid_pipe_reg_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  ex_skid_pipe_reg #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
`ifdef STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  ent_t mq[$];
  ent_t last_head;
  int   stall_m = 0;
  ent_t cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input ent_t e, input logic rdy);
    cur                    = e;
    bus.in_valid           = v;
    bus.rs_in              = e.rs;
    bus.rt_in              = e.rt;
    bus.ALU_result_in      = e.alu;
    bus.reg_writesel_in    = e.sel;
    bus.reg_write_en_in    = e.we;
    bus.RAM_writeEnable_in = e.ram;
    bus.MemtoReg_in        = e.m2r;
    bus.PC_en_in           = e.pc;
    bus.cache_Ready        = rdy;
  endtask

  function automatic ent_t mk(input logic [DATA_W-1:0] alu, input logic ram);
    ent_t e;
    e.rs  = DATA_W'($urandom);
    e.rt  = DATA_W'($urandom);
    e.alu = alu;
    e.sel = SEL_W'($urandom);
    e.we  = 1'($urandom);
    e.ram = ram;
    e.m2r = 1'($urandom);
    e.pc  = 1'($urandom);
    return e;
  endfunction

  task automatic check_all();
    ent_t e;
    logic ov;
    ov = (mq.size() > 0);
    e  = ov ? mq[0] : last_head;
    chk("out_valid", 32'(bus.out_valid), 32'(ov));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
    chk("rs_out", 32'(bus.rs_out), 32'(e.rs));
    chk("rt_out", 32'(bus.rt_out), 32'(e.rt));
    chk("alu_out", 32'(bus.ALU_result_out), 32'(e.alu));
    chk("sel_out", 32'(bus.reg_writesel_out), 32'(e.sel));
    chk("we_out", 32'(bus.reg_write_en_out), 32'(ov && e.we));
    chk("ram_out", 32'(bus.RAM_writeEnable_out), 32'(ov && e.ram));
    chk("m2r_out", 32'(bus.MemtoReg_out), 32'(ov && e.m2r));
    chk("pc_out", 32'(bus.PC_en_out), 32'(!ov || e.pc));
`ifdef STALL_CNT_EN
    chk("stall_count", 32'(stall_count), 32'(stall_m));
`endif
  endtask

  // One falling edge: advance the queue model, wait the edge, compare on the rising edge.
  task automatic tick();
    bit acc, drn;
    acc = bus.in_valid && (mq.size() < 2);
    drn = (mq.size() > 0) && bus.cache_Ready;
    if (reset) stall_m = 0;
    else if (mq.size() > 0 && !bus.cache_Ready && stall_m < CNT_MAX) stall_m++;
    if (reset || flush) begin
      mq.delete();
      last_head = '0;
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(cur);
      if (mq.size() > 0) last_head = mq[0];
    end
    @(negedge clk);
    @(posedge clk);
    check_all();
  endtask

  initial begin
    ent_t e;
    reset = 1'b1;
    flush = 1'b0;
    last_head = '0;
    drive(1'b0, '0, 1'b0);

    // reset for two edges
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_pc_en", 32'(bus.PC_en_out), 32'd1);
    chk("rst_alu", 32'(bus.ALU_result_out), 32'd0);
    reset = 1'b0;

    // streaming 1,2,3
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, mk(DATA_W'(k), 1'b0), 1'b1);
      tick();
      chk("stream_alu", 32'(bus.ALU_result_out), 32'(k));
      chk("stream_rdy", 32'(bus.in_ready), 32'd1);
    end
    drive(1'b0, mk(0, 1'b0), 1'b1);
    tick();

    // backpressure into the skid slot
    drive(1'b1, mk(10'h003, 1'b0), 1'b1);
    tick();
    drive(1'b1, mk(10'h007, 1'b0), 1'b0);
    tick();
    chk("skid_rdy", 32'(bus.in_ready), 32'd0);
    chk("skid_hold", 32'(bus.ALU_result_out), 32'h003);
    drive(1'b1, mk(10'h00F, 1'b0), 1'b0);
    tick();
    drive(1'b0, mk(0, 1'b0), 1'b1);
    tick();
    chk("drain1_alu", 32'(bus.ALU_result_out), 32'h007);
    chk("drain1_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    chk("drain2_empty", 32'(bus.out_valid), 32'd0);

    // flush while full
    drive(1'b1, mk(10'h011, 1'b1), 1'b0);
    tick();
    drive(1'b1, mk(10'h012, 1'b0), 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, mk(10'h013, 1'b1), 1'b0);
    tick();
    flush = 1'b0;
    chk("flush_ov", 32'(bus.out_valid), 32'd0);
    chk("flush_ram", 32'(bus.RAM_writeEnable_out), 32'd0);
    chk("flush_pc", 32'(bus.PC_en_out), 32'd1);
    chk("flush_rdy", 32'(bus.in_ready), 32'd1);

    // bubble with live control inputs
    e = mk(0, 1'b0);
    e.we = 1'b1;
    e.rs = 10'h155;
    drive(1'b0, e, 1'b1);
    tick();
    chk("bubble_we", 32'(bus.reg_write_en_out), 32'd0);

    // long stall: counter saturates, survives flush, cleared by reset
    drive(1'b1, mk(10'h021, 1'b0), 1'b0);
    tick();
    drive(1'b0, mk(0, 1'b0), 1'b0);
    for (int k = 0; k < 5; k++) tick();
`ifdef STALL_CNT_EN
    chk("stall_sat", 32'(stall_count), 32'(CNT_MAX));
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef STALL_CNT_EN
    chk("stall_flush", 32'(stall_count), 32'(CNT_MAX));
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_ov", 32'(bus.out_valid), 32'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(63) == 0);
      flush = ($urandom_range(31) == 0);
      drive(($urandom_range(9) < 7), mk(DATA_W'($urandom), 1'($urandom)),
            ($urandom_range(9) < 6));
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
